// File: rtl/song_note_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song note sequencer, the score logic and the
// display:
//   - default field widths of the song ROM word {note, duration}
//   - rest note and end-of-song marker values
//   - sequencer FSM state enum
//   - field-extract helpers for a ROM word
//   - note code constants (0 is a rest)
// ---------------------------------------------------------------------------
package song_pkg;

    localparam int NOTE_W = 3;
    localparam int DUR_W  = 5;
    localparam int ADDR_W = 8;
    localparam int WORD_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    localparam logic [DUR_W-1:0]  END_DUR   = '0;

    // Note codes shared with the score logic and the display.
    localparam logic [NOTE_W-1:0] NOTE_C = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_D = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_E = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_F = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_G = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_A = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_B = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_PLAY  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/song_note_sequencer_beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer
// Tick divider plus beat counter for one note.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : count enable (PLAY and not paused)
//   clr_i        : clear both counters (note load)
//   dur_i        : note length in beats
//   beat_tick_o  : high in the cycle where the tick divider wraps
//   beat_done_o  : high on the wrap that completes the last beat of the note
// Both outputs are combinational from the counters so the sequencer can leave
// PLAY on the very edge that ends the final beat.
// ---------------------------------------------------------------------------
module beat_timer #(
    parameter int TICKS_PER_BEAT = 4,
    parameter int DUR_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DUR_W-1:0] dur_i,
    output logic             beat_tick_o,
    output logic             beat_done_o
);

    localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DUR_W-1:0]  beat_next;
    logic              wrap;

    // A wrap only happens while enabled, so pause defers it.
    assign wrap      = en_i && (tick_cnt_q == TICK_LAST);
    assign beat_next = beat_cnt_q + DUR_W'(1);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (clr_i) begin
            tick_cnt_d = '0;
            beat_cnt_d = '0;
        end else if (en_i) begin
            if (wrap) begin
                tick_cnt_d = '0;
                beat_cnt_d = beat_next;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_tick_o = wrap;
    assign beat_done_o = wrap && (beat_next == dur_i);

endmodule

// File: rtl/song_note_sequencer.sv
// ---------------------------------------------------------------------------
// song_note_sequencer
// Walks a synchronous song ROM of {note, duration} words and presents the
// expected note to the score logic, holding each note for duration beats.
// Optional build macro: SONG_LOOP_EN -- the end marker restarts the song at
// address 0 with a one-cycle song_done pulse instead of entering DONE.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : level; starts playback from address 0 in IDLE or DONE
//   pause         : level; freezes beat timing while in PLAY
//   rom_addr      : song ROM address
//   rom_data      : ROM word {note, duration}, valid one cycle after rom_addr
//   current_note  : expected note, bit range [NOTE_W:1]
//   note_strobe   : one-cycle pulse when current_note is loaded
//   beat_tick     : one-cycle pulse at each beat boundary in PLAY
//   playing       : high in FETCH/WAIT/LOAD/PLAY
//   song_done     : high in DONE (one-cycle pulse per loop with SONG_LOOP_EN)
//   dbg_state     : current FSM state
// Handshake: there is none; start and pause are sampled levels, and every
// output is valid each cycle with strobes lasting exactly one cycle.
// ---------------------------------------------------------------------------
module song_note_sequencer
    import song_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 12500000,
    parameter int ADDR_W         = song_pkg::ADDR_W,
    parameter int NOTE_W         = song_pkg::NOTE_W,
    parameter int DUR_W          = song_pkg::DUR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W:1]         current_note,
    output logic                    note_strobe,
    output logic                    beat_tick,
    output logic                    playing,
    output logic                    song_done,
    output state_e                  dbg_state
);

    localparam int WW = NOTE_W + DUR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0] note_lat_q, note_lat_d;
    logic [DUR_W-1:0]  dur_lat_q, dur_lat_d;
    logic [NOTE_W-1:0] current_note_q, current_note_d;
    logic              note_strobe_q, note_strobe_d;
    logic              song_done_q, song_done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              timer_en, timer_clr;
    logic              beat_tick_w, beat_done_w;

    assign rom_note = rom_data[WW-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    assign timer_en  = (state_q == ST_PLAY) && !pause;
    assign timer_clr = (state_q == ST_LOAD);

    beat_timer #(
        .TICKS_PER_BEAT (TICKS_PER_BEAT),
        .DUR_W          (DUR_W)
    ) u_beat_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (timer_en),
        .clr_i       (timer_clr),
        .dur_i       (dur_lat_q),
        .beat_tick_o (beat_tick_w),
        .beat_done_o (beat_done_w)
    );

    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        note_lat_d     = note_lat_q;
        dur_lat_d      = dur_lat_q;
        current_note_d = current_note_q;
        note_strobe_d  = 1'b0;
        song_done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rom_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            // Address is stable this cycle; the ROM registers it on the edge.
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                note_lat_d = rom_note;
                dur_lat_d  = rom_dur;
                if (rom_dur == DUR_W'(END_DUR)) begin
`ifdef SONG_LOOP_EN
                    rom_addr_d  = '0;
                    song_done_d = 1'b1;
                    state_d     = ST_FETCH;
`else
                    current_note_d = NOTE_W'(NOTE_REST);
                    song_done_d    = 1'b1;
                    state_d        = ST_DONE;
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                current_note_d = note_lat_q;
                note_strobe_d  = 1'b1;
                state_d        = ST_PLAY;
            end
            ST_PLAY: begin
                // Address increment wraps naturally past the top of the ROM.
                if (beat_done_w) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = ST_FETCH;
                end
            end
            ST_DONE: begin
                current_note_d = NOTE_W'(NOTE_REST);
                song_done_d    = 1'b1;
                if (start) begin
                    rom_addr_d  = '0;
                    song_done_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rom_addr_q     <= '0;
            note_lat_q     <= '0;
            dur_lat_q      <= '0;
            current_note_q <= '0;
            note_strobe_q  <= 1'b0;
            song_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            note_lat_q     <= note_lat_d;
            dur_lat_q      <= dur_lat_d;
            current_note_q <= current_note_d;
            note_strobe_q  <= note_strobe_d;
            song_done_q    <= song_done_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign current_note = current_note_q;
    assign note_strobe  = note_strobe_q;
    assign beat_tick    = beat_tick_w;
    assign playing      = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                          (state_q == ST_LOAD)  || (state_q == ST_PLAY);
    assign song_done    = song_done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_song_note_sequencer.sv
`timescale 1ns/1ps
module tb_song_note_sequencer;
    import song_pkg::*;

    localparam int TPB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, pause;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:1] current_note;
    logic       note_strobe, beat_tick, playing, song_done;
    state_e     dbg_state;
    logic [7:0] rom [0:255];

    logic       w_rst_n, w_start, w_pause;
    logic [1:0] w_rom_addr;
    logic [7:0] w_rom_data;
    logic [3:1] w_current_note;
    logic       w_note_strobe, w_beat_tick, w_playing, w_song_done;
    state_e     w_dbg_state;
    logic [7:0] w_rom [0:3];

    always @(posedge clk) rom_data   <= rom[rom_addr];
    always @(posedge clk) w_rom_data <= w_rom[w_rom_addr];

    song_note_sequencer #(.TICKS_PER_BEAT(TPB), .ADDR_W(8), .NOTE_W(3), .DUR_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data), .current_note(current_note),
        .note_strobe(note_strobe), .beat_tick(beat_tick), .playing(playing),
        .song_done(song_done), .dbg_state(dbg_state)
    );

    // Two-bit address space with no end marker: exercises the address wrap.
    song_note_sequencer #(.TICKS_PER_BEAT(TPB), .ADDR_W(2), .NOTE_W(3), .DUR_W(5)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .start(w_start), .pause(w_pause),
        .rom_addr(w_rom_addr), .rom_data(w_rom_data), .current_note(w_current_note),
        .note_strobe(w_note_strobe), .beat_tick(w_beat_tick), .playing(w_playing),
        .song_done(w_song_done), .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fails  = 0;

    // {note, PLAY cycles the note lasted, beat ticks seen while it lasted}
    logic [15:0] exp_q[$];
    // {rom_addr, note} at each strobe of the wrap instance
    logic [7:0]  wexp_q[$];

    function automatic logic [15:0] pk(input logic [2:0] n, input int cyc, input int tk);
        logic [7:0] c8;
        logic [4:0] t5;
        c8 = cyc[7:0];
        t5 = tk[4:0];
        return {n, c8, t5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always begin : mon_main
        logic [2:0] m_note;
        int         m_cyc;
        int         m_tk;
        @(negedge clk);
        if (rst_n && note_strobe) begin
            m_note = current_note;
            m_cyc  = 0;
            m_tk   = 0;
            while (dbg_state == ST_PLAY && m_cyc < 200) begin
                m_cyc++;
                m_tk += int'(beat_tick);
                @(negedge clk);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_strobe: note %0d, no expected entry", m_note);
            end else begin
                check("note_hold", 32'(pk(m_note, m_cyc, m_tk)), 32'(exp_q.pop_front()));
            end
        end
    end

    always begin : mon_wrap
        @(negedge clk);
        if (w_rst_n && w_note_strobe) begin
            if (wexp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL wrap_unexpected_strobe: addr %0d note %0d", w_rom_addr, w_current_note);
            end else begin
                check("wrap_addr_note", 32'({3'b0, w_rom_addr, w_current_note}), 32'(wexp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2ns after the rising edge; outputs are read on the falling edge.
    task automatic drive_start_and_check_latency();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;    // edge N sampled start
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("strobe_not_early", 32'(note_strobe), 32'd0);
        @(posedge clk);                     // edge N+3
        @(negedge clk);
        check("latency_strobe", 32'(note_strobe), 32'd1);
        check("latency_note", 32'(current_note), 32'd5);
        check("latency_addr", 32'(rom_addr), 32'd0);
        check("latency_playing", 32'(playing), 32'd1);
        check("latency_song_done", 32'(song_done), 32'd0);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (!song_done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(song_done), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int act;
        int n;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = {3'd5, 5'd2};
        rom[1] = {3'd3, 5'd1};
        rom[2] = {3'd0, 5'd0};
        for (int i = 0; i < 4; i++) w_rom[i] = {3'(i + 1), 5'd1};

        rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        w_rst_n = 1'b0; w_start = 1'b0; w_pause = 1'b0;

        // Reset, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_note", 32'(current_note), 32'd0);
        check("rst_strobe", 32'(note_strobe), 32'd0);
        check("rst_tick", 32'(beat_tick), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_done", 32'(song_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #2 rst_n = 1'b1; w_rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (note_strobe || beat_tick || playing || song_done || rom_addr != 8'd0) act++;
        end
        check("idle_quiet", 32'(act), 32'd0);

`ifdef SONG_LOOP_EN
        // Looping song: the end marker restarts at address 0.
        exp_q.push_back(pk(3'd5, 8, 2));
        exp_q.push_back(pk(3'd3, 4, 1));
        exp_q.push_back(pk(3'd5, 8, 2));
        drive_start_and_check_latency();
        wait_done(200);
        check("loop_playing", 32'(playing), 32'd1);
        check("loop_state", 32'(dbg_state), 32'(ST_FETCH));
        check("loop_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        check("loop_done_pulse", 32'(song_done), 32'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #2 rst_n = 1'b0;
        check("loop_queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("loop_rst_state", 32'(dbg_state), 32'(ST_IDLE));
`else
        // Basic song with a 10-cycle pause and an ignored start mid-note.
        exp_q.push_back(pk(3'd5, 18, 2));
        exp_q.push_back(pk(3'd3, 4, 1));
        drive_start_and_check_latency();
        @(posedge clk); #2 pause = 1'b1;
        repeat (10) @(posedge clk);
        #2 pause = 1'b0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        check("ignore_start_state", 32'(dbg_state), 32'(ST_PLAY));
        check("ignore_start_addr", 32'(rom_addr), 32'd0);
        wait_done(200);
        check("done_note", 32'(current_note), 32'd0);
        check("done_playing", 32'(playing), 32'd0);
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        check("done_addr", 32'(rom_addr), 32'd2);
        repeat (5) @(negedge clk);
        check("done_sticky", 32'(song_done), 32'd1);
        check("song1_queue_drained", 32'(exp_q.size()), 32'd0);

        // Restart from DONE, no pause.
        exp_q.push_back(pk(3'd5, 8, 2));
        exp_q.push_back(pk(3'd3, 4, 1));
        drive_start_and_check_latency();
        wait_done(200);
        check("done2_note", 32'(current_note), 32'd0);
        check("song2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a note: three PLAY cycles, no beat yet.
        exp_q.push_back(pk(3'd5, 3, 0));
        drive_start_and_check_latency();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_note", 32'(current_note), 32'd0);
        check("midrst_playing", 32'(playing), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_strobe", 32'(note_strobe), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (note_strobe || playing) act++;
        end
        check("midrst_quiet", 32'(act), 32'd0);
        check("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
`endif

        // Address wrap on the 2-bit instance: 0,1,2,3,0.
        wexp_q.push_back({3'b0, 2'd0, 3'd1});
        wexp_q.push_back({3'b0, 2'd1, 3'd2});
        wexp_q.push_back({3'b0, 2'd2, 3'd3});
        wexp_q.push_back({3'b0, 2'd3, 3'd4});
        wexp_q.push_back({3'b0, 2'd0, 3'd1});
        @(posedge clk); #2 w_start = 1'b1;
        @(posedge clk); #2 w_start = 1'b0;
        n = 0;
        while (wexp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #2 w_rst_n = 1'b0;
        check("wrap_queue_drained", 32'(wexp_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
